div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: W, 10, operand/quotient width (matches divider datapath).
REQ-002 Parameter: TMO_CYCLES, 64, watchdog limit in cycles (used only with DIV_ARB_TMO_EN).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: sclr  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 Ports: req0, req1  in  1  requester i asks for a division; held high until ack_i.
REQ-006 Ports: a0, b0, a1, b1  in  W  dividend/divisor of requester i; stable while req_i high.
REQ-007 Ports: ack0, ack1  out  1  one-cycle result strobe to requester i.
REQ-008 Ports: q_out  out  W; dvz_out, ovf_out, err_out  out  1  result and status, valid only while an ack is high.
REQ-009 Ports: div_start  out  1; div_A, div_B  out  W  command to divider.
REQ-010 Ports: div_busy, div_valid, div_dvz, div_ovf  in  1; div_Q  in  W  divider response.
REQ-011 Port: grant  out  1  index of the requester currently owned (0/1); busy  out  1  high in any state except IDLE.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP; encoding free, one state per cycle minimum.
REQ-013 IDLE: if any req_i high, select winner, latch a_i/b_i into div_A/div_B, set grant, go ISSUE; else stay.
REQ-014 Arbitration: round-robin; single request wins outright; both high -> the port with priority wins; after each RESP, priority moves to the other port.
REQ-015 Zero divisor: if latched divisor == 0, ISSUE skips divider (div_start stays 0), goes to RESP with dvz_out=1, q_out=all ones, ovf_out=0.
REQ-016 ISSUE (non-zero divisor): div_start=1 for exactly this one cycle; next state WAIT.
REQ-017 WAIT: on div_valid sampled high, capture div_Q, div_dvz, div_ovf; go RESP; div_valid seen in ISSUE is ignored.
REQ-018 RESP: ack_grant=1 for exactly one cycle with captured results; other ack 0; next state IDLE.
REQ-019 Requester drops req_i at the edge that samples ack_i high; req_i high in IDLE is always a new request.
REQ-020 Latency: ack asserted exactly one cycle after div_valid sampled; zero-divisor path: ack two cycles after grant.
REQ-021 div_A/div_B held constant from grant until leaving RESP; never change while div_busy high.
REQ-022 A req deasserted by a non-granted requester has no effect; the granted request is never withdrawn.
REQ-023 Never ack0 and ack1 high together; never more than one div_start per grant.

Reset
REQ-024 sclr low at a rising edge: state=IDLE, priority=port 0, ack0=ack1=0, div_start=0, div_A=div_B=0, q_out=0, dvz_out=ovf_out=err_out=0, grant=0, busy=0, watchdog=0.
REQ-025 Reset mid-operation (ISSUE/WAIT/RESP) aborts without ack; any in-flight divider result after reset is ignored.

Configuration
REQ-026 Macro DIV_ARB_TMO_EN defined: WAIT counts cycles from entry; if TMO_CYCLES cycles elapse without div_valid, go RESP with err_out=1, q_out=0, dvz_out=ovf_out=0; counter clears on leaving WAIT.
REQ-027 Macro absent: no counter logic, err_out tied 0, WAIT waits indefinitely.

Verification
REQ-028 req0 only, a0=100, b0=5; divider returns Q=20 -> one div_start, ack0 one cycle after div_valid, q_out=20, ack1 never.
REQ-029 req0 and req1 in same cycle after reset (a0=9,b0=3,a1=8,b1=2) -> port 0 served first (q=3), then port 1 (q=4); third simultaneous pair served port 0 after port 1.
REQ-030 req1 with b1=0 -> div_start never pulses, ack1 two cycles after grant, dvz_out=1, q_out=10'h3FF.
REQ-031 sclr low during WAIT, then late div_valid -> no ack, state IDLE, all outputs at reset values.
REQ-032 DIV_ARB_TMO_EN, TMO_CYCLES=64, divider never asserts div_valid -> ack with err_out=1 exactly 64 cycles after WAIT entry; without macro, no ack.
REQ-033 div_valid held high through ISSUE and WAIT of a back-to-back request -> exactly one ack per grant, each with matching div_Q.

Source files
------------

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-port round-robin arbiter in front of a shared divider
// Optional watchdog on the divider response: define DIV_ARB_TMO_EN.
module div_arbiter #(
  parameter int W          = 10,
  parameter int TMO_CYCLES = 64
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] q_out,
  output logic         dvz_out,
  output logic         ovf_out,
  output logic         err_out,
  output logic         div_start,
  output logic [W-1:0] div_A,
  output logic [W-1:0] div_B,
  input  logic         div_busy,
  input  logic         div_valid,
  input  logic         div_dvz,
  input  logic         div_ovf,
  input  logic [W-1:0] div_Q,
  output logic         grant,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic   prio;
  logic   win;
  logic   tmo_hit;
  logic   unused_busy;

  // The handshake is driven purely by div_valid; busy is informational only.
  assign unused_busy = div_busy;

  assign win       = (req0 && req1) ? prio : req1;
  assign ack0      = (state == RESP) && !grant;
  assign ack1      = (state == RESP) && grant;
  assign busy      = (state != IDLE);
  assign div_start = (state == ISSUE) && (div_B != '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = ISSUE;
      ISSUE:   state_nx = (div_B == '0) ? RESP : WAIT;
      WAIT:    if (div_valid || tmo_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sclr) begin
      state   <= IDLE;
      prio    <= 1'b0;
      grant   <= 1'b0;
      div_A   <= '0;
      div_B   <= '0;
      q_out   <= '0;
      dvz_out <= 1'b0;
      ovf_out <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant <= win;
            div_A <= win ? a1 : a0;
            div_B <= win ? b1 : b0;
          end
        end
        ISSUE: begin
          if (div_B == '0) begin
            q_out   <= '1;
            dvz_out <= 1'b1;
            ovf_out <= 1'b0;
          end
        end
        WAIT: begin
          if (div_valid) begin
            q_out   <= div_Q;
            dvz_out <= div_dvz;
            ovf_out <= div_ovf;
          end else if (tmo_hit) begin
            q_out   <= '0;
            dvz_out <= 1'b0;
            ovf_out <= 1'b0;
          end
        end
        RESP:    prio <= ~grant;
        default: ;
      endcase
    end
  end

`ifdef DIV_ARB_TMO_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // The counter value equals the number of WAIT cycles already completed.
  assign tmo_hit = (state == WAIT) && !div_valid && (wd_cnt == CW'(TMO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!sclr) begin
      wd_cnt  <= '0;
      err_out <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT && state_nx == WAIT) ? wd_cnt + 1'b1 : '0;
      if (state != RESP && state_nx == RESP) err_out <= tmo_hit;
    end
  end
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = 32'(TMO_CYCLES);
  assign tmo_hit    = 1'b0;
  assign err_out    = 1'b0;
`endif

endmodule
